// File: rtl/evr_stream_decoder.sv
// rtl/evr_stream_decoder.sv - EVR word-stream splitter: events, distributed bus, data-buffer frames
// Link qualification and code-error counting share the recovered ref_clk domain.
module evr_stream_decoder #(
    parameter int LINK_GOOD_WORDS = 256,
    parameter int MAX_BYTES       = 2048,
    parameter int ADDR_W          = 11
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic [15:0]       rx_data,
    input  logic [1:0]        rx_charisk,
    input  logic [1:0]        rx_notintable,
    input  logic              rx_reset_done,
    input  logic              err_clr,
    output logic [7:0]        event_code,
    output logic              event_strobe,
    output logic [7:0]        dbus,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [7:0]        buf_wr_data,
    output logic              buf_done,
    output logic              buf_ok,
    output logic [ADDR_W-1:0] buf_len,
    output logic              link_up,
    output logic [15:0]       err_count
);
    localparam int GW = (LINK_GOOD_WORDS > 2) ? $clog2(LINK_GOOD_WORDS) : 1;
    // Index must reach MAX_BYTES+2 to detect overflow, so it may be wider than the RAM address.
    localparam int IW = $clog2(MAX_BYTES + 3);

    typedef enum logic {S_IDLE, S_RX} state_t;

    state_t          r_state;
    logic [GW-1:0]   r_good_cnt;
    logic            r_next_slot;
    logic [IW-1:0]   r_index;
    logic [15:0]     r_sum;
    logic [7:0]      r_b_prev;
    logic [7:0]      r_b_last;

    logic [7:0]      w_ev_byte;
    logic [7:0]      w_d_byte;
    logic            w_bad;
    logic            w_slot;
    logic [15:0]     w_payload;
    logic            w_ck_ok;

    assign w_ev_byte = rx_data[15:8];
    assign w_d_byte  = rx_data[7:0];
    assign w_bad     = (rx_notintable != 2'b00) || !rx_reset_done;
    assign w_slot    = (rx_charisk[1] && (w_ev_byte == 8'hBC)) ? 1'b0 : r_next_slot;
    assign w_payload = r_sum - {8'h00, r_b_prev} - {8'h00, r_b_last};
    assign w_ck_ok   = ((w_payload + {r_b_prev, r_b_last}) == 16'hFFFF);

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_good_cnt   <= '0;
            r_next_slot  <= 1'b0;
            r_index      <= '0;
            r_sum        <= '0;
            r_b_prev     <= '0;
            r_b_last     <= '0;
            event_code   <= '0;
            event_strobe <= 1'b0;
            dbus         <= '0;
            buf_wr_en    <= 1'b0;
            buf_wr_addr  <= '0;
            buf_wr_data  <= '0;
            buf_done     <= 1'b0;
            buf_ok       <= 1'b0;
            buf_len      <= '0;
            link_up      <= 1'b0;
            err_count    <= '0;
        end else begin
            event_strobe <= 1'b0;
            buf_wr_en    <= 1'b0;
            buf_done     <= 1'b0;

            if (w_bad) begin
                r_good_cnt <= '0;
                link_up    <= 1'b0;
            end else if (r_good_cnt == GW'(LINK_GOOD_WORDS - 1)) begin
                link_up    <= 1'b1;
            end else begin
                r_good_cnt <= r_good_cnt + 1'b1;
            end

            if (err_clr)
                err_count <= '0;
            else if ((rx_notintable != 2'b00) && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;

            if (link_up && !rx_charisk[1] && (w_ev_byte != 8'h00) && !w_bad) begin
                event_strobe <= 1'b1;
                event_code   <= w_ev_byte;
            end

            r_next_slot <= ~w_slot;
            if (!w_slot && !rx_charisk[0] && link_up)
                dbus <= w_d_byte;

            case (r_state)
                S_IDLE: begin
                    if (w_slot && rx_charisk[0] && (w_d_byte == 8'h1C) && link_up && !w_bad) begin
                        r_state  <= S_RX;
                        r_index  <= '0;
                        r_sum    <= '0;
                        r_b_prev <= '0;
                        r_b_last <= '0;
                    end
                end
                S_RX: begin
                    if (w_bad || !link_up) begin
                        r_state  <= S_IDLE;
                        buf_done <= 1'b1;
                        buf_ok   <= 1'b0;
                        buf_len  <= '0;
                    end else if (w_slot) begin
                        if (!rx_charisk[0]) begin
                            if (r_index == IW'(MAX_BYTES + 2)) begin
                                r_state  <= S_IDLE;
                                buf_done <= 1'b1;
                                buf_ok   <= 1'b0;
                                buf_len  <= '0;
                            end else begin
                                buf_wr_en   <= 1'b1;
                                buf_wr_addr <= ADDR_W'(r_index);
                                buf_wr_data <= w_d_byte;
                                r_index     <= r_index + 1'b1;
                                r_sum       <= r_sum + {8'h00, w_d_byte};
                                r_b_prev    <= r_b_last;
                                r_b_last    <= w_d_byte;
                            end
                        end else if (w_d_byte == 8'h3C) begin
                            r_state  <= S_IDLE;
                            buf_done <= 1'b1;
                            if (r_index >= IW'(2)) begin
                                buf_len <= ADDR_W'(r_index - IW'(2));
                                buf_ok  <= w_ck_ok;
                            end else begin
                                buf_len <= '0;
                                buf_ok  <= 1'b0;
                            end
                        end else if (w_d_byte == 8'h1C) begin
                            r_index  <= '0;
                            r_sum    <= '0;
                            r_b_prev <= '0;
                            r_b_last <= '0;
                        end else begin
                            r_state  <= S_IDLE;
                            buf_done <= 1'b1;
                            buf_ok   <= 1'b0;
                            buf_len  <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_evr_stream_decoder.sv
// tb/tb_evr_stream_decoder.sv - self-checking bench for evr_stream_decoder
module tb_evr_stream_decoder;
    localparam int LGW = 256;
    localparam int MAXB = 16;
    localparam int AW = 5;

    logic          ref_clk = 1'b0;
    logic          reset;
    logic [15:0]   rx_data;
    logic [1:0]    rx_charisk;
    logic [1:0]    rx_notintable;
    logic          rx_reset_done;
    logic          err_clr;
    logic [7:0]    event_code;
    logic          event_strobe;
    logic [7:0]    dbus;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [7:0]    buf_wr_data;
    logic          buf_done;
    logic          buf_ok;
    logic [AW-1:0] buf_len;
    logic          link_up;
    logic [15:0]   err_count;

    int n_pass = 0;
    int n_total = 0;

    evr_stream_decoder #(.LINK_GOOD_WORDS(LGW), .MAX_BYTES(MAXB), .ADDR_W(AW)) dut (
        .ref_clk(ref_clk), .reset(reset), .rx_data(rx_data), .rx_charisk(rx_charisk),
        .rx_notintable(rx_notintable), .rx_reset_done(rx_reset_done), .err_clr(err_clr),
        .event_code(event_code), .event_strobe(event_strobe), .dbus(dbus),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_done(buf_done), .buf_ok(buf_ok), .buf_len(buf_len),
        .link_up(link_up), .err_count(err_count)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        logic [15:0]   d;
        logic [1:0]    k;
        logic          e_stb;
        logic [7:0]    e_code;
        logic [7:0]    e_dbus;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_wdata;
        logic          e_done;
        logic          e_ok;
        logic [AW-1:0] e_len;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic [1:0] nit);
        rx_data = d;
        rx_charisk = k;
        rx_notintable = nit;
        @(posedge ref_clk);
        #1;
    endtask

    task automatic fk(input logic [7:0] b);
        send(16'hBC5A, 2'b10, 2'b00);
        send({8'h00, b}, 2'b01, 2'b00);
    endtask

    task automatic fb(input logic [7:0] b);
        send(16'hBC5A, 2'b10, 2'b00);
        send({8'h00, b}, 2'b00, 2'b00);
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] k, input logic stb,
                        input logic [7:0] code, input logic [7:0] db, input logic wr,
                        input logic [AW-1:0] a, input logic [7:0] wd, input logic dn,
                        input logic ok, input logic [AW-1:0] len);
        vec_t v;
        v.d = d; v.k = k; v.e_stb = stb; v.e_code = code; v.e_dbus = db;
        v.e_wr = wr; v.e_addr = a; v.e_wdata = wd; v.e_done = dn; v.e_ok = ok; v.e_len = len;
        vecs.push_back(v);
    endtask

    // Frame byte pairs inside the table: comma word in slot 0, frame byte in slot 1.
    task automatic push_fb(input logic [7:0] b, input logic [AW-1:0] a);
        push(16'hBC5A, 2'b10, 0, 8'h2A, 8'h5A, 0, '0, 8'h00, 0, 0, '0);
        push({8'h00, b}, 2'b00, 0, 8'h2A, 8'h5A, 1, a, b, 0, 0, '0);
    endtask

    task automatic push_fk(input logic [7:0] b, input logic dn, input logic ok, input logic [AW-1:0] len);
        push(16'hBC5A, 2'b10, 0, 8'h2A, 8'h5A, 0, '0, 8'h00, 0, 0, '0);
        push({8'h00, b}, 2'b01, 0, 8'h2A, 8'h5A, 0, '0, 8'h00, dn, ok, len);
    endtask

    task automatic qualify();
        repeat (LGW) send(16'hBC00, 2'b10, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        rx_data = 16'hBC00;
        rx_charisk = 2'b10;
        rx_notintable = 2'b00;
        rx_reset_done = 1'b1;
        err_clr = 1'b0;
        repeat (3) @(posedge ref_clk);
        #1;
        chk("reset_outputs", {9'd0, event_code, event_strobe, dbus, buf_wr_en, buf_wr_addr,
             buf_wr_data, buf_done, buf_ok, buf_len, link_up, err_count}, 64'd0);
        reset = 1'b0;

        repeat (LGW - 1) send(16'hBC00, 2'b10, 2'b00);
        chk("link_before_256", {63'd0, link_up}, 64'd0);
        send(16'hBC00, 2'b10, 2'b00);
        chk("link_at_256", {63'd0, link_up}, 64'd1);
        chk("err_after_link", {48'd0, err_count}, 64'd0);

        push(16'h2A00, 2'b00, 1, 8'h2A, 8'h00, 0, '0, 8'h00, 0, 0, '0);
        push(16'h0000, 2'b00, 0, 8'h2A, 8'h00, 0, '0, 8'h00, 0, 0, '0);
        push(16'hBC5A, 2'b10, 0, 8'h2A, 8'h5A, 0, '0, 8'h00, 0, 0, '0);
        push(16'h0077, 2'b00, 0, 8'h2A, 8'h5A, 0, '0, 8'h00, 0, 0, '0);
        push_fk(8'h1C, 0, 0, '0);
        push_fb(8'h01, 5'd0); push_fb(8'h02, 5'd1); push_fb(8'h03, 5'd2);
        push_fb(8'hFF, 5'd3); push_fb(8'hF9, 5'd4);
        push_fk(8'h3C, 1, 1, 5'd3);
        push_fk(8'h1C, 0, 0, '0);
        push_fb(8'h01, 5'd0); push_fb(8'h02, 5'd1); push_fb(8'h03, 5'd2);
        push_fb(8'hFF, 5'd3); push_fb(8'hF8, 5'd4);
        push_fk(8'h3C, 1, 0, 5'd3);
        push(16'h3100, 2'b00, 1, 8'h31, 8'h00, 0, '0, 8'h00, 0, 0, '0);
        push(16'hFC00, 2'b10, 0, 8'h31, 8'h00, 0, '0, 8'h00, 0, 0, '0);

        foreach (vecs[i]) begin
            vec_t v;
            logic ok;
            v = vecs[i];
            send(v.d, v.k, 2'b00);
            ok = (event_strobe === v.e_stb) && (event_code === v.e_code) && (dbus === v.e_dbus)
                && (buf_wr_en === v.e_wr) && (!v.e_wr || (buf_wr_addr === v.e_addr && buf_wr_data === v.e_wdata))
                && (buf_done === v.e_done) && (!v.e_done || (buf_ok === v.e_ok && buf_len === v.e_len))
                && (link_up === 1'b1) && (err_count === 16'h0000);
            n_total++;
            if (ok) n_pass++;
            else $display("FAIL vec%0d: got stb=%b code=%h dbus=%h wr=%b a=%h d=%h done=%b ok=%b len=%0d link=%b err=%h; need stb=%b code=%h dbus=%h wr=%b a=%h d=%h done=%b ok=%b len=%0d",
                          i, event_strobe, event_code, dbus, buf_wr_en, buf_wr_addr, buf_wr_data,
                          buf_done, buf_ok, buf_len, link_up, err_count, v.e_stb, v.e_code, v.e_dbus,
                          v.e_wr, v.e_addr, v.e_wdata, v.e_done, v.e_ok, v.e_len);
        end

        // Code error mid-frame
        fk(8'h1C);
        fb(8'h11);
        send(16'hBC5A, 2'b10, 2'b01);
        chk("err_abort", {43'd0, buf_wr_en, buf_done, buf_ok, buf_len, link_up, err_count},
            {43'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 16'd1});
        send(16'hBC00, 2'b10, 2'b00);
        chk("done_one_cycle", {63'd0, buf_done}, 64'd0);
        qualify();
        chk("relink", {63'd0, link_up}, 64'd1);

        repeat (70000) send(16'hBC00, 2'b10, 2'b10);
        chk("err_saturate", {47'd0, link_up, err_count}, {47'd0, 1'b0, 16'hFFFF});
        err_clr = 1'b1;
        send(16'hBC00, 2'b10, 2'b01);
        err_clr = 1'b0;
        chk("err_clr", {48'd0, err_count}, 64'd0);
        qualify();

        // Overflow: MAXB+2 bytes land, next byte aborts
        fk(8'h1C);
        for (int i = 0; i < MAXB + 2; i++) begin
            fb(8'(i + 1));
            chk($sformatf("ovf_wr%0d", i), {55'd0, buf_wr_en, 3'd0, buf_wr_addr}, {55'd0, 1'b1, 3'd0, 5'(i)});
        end
        fb(8'h55);
        chk("ovf_abort", {56'd0, buf_wr_en, buf_done, buf_ok, buf_len}, {56'd0, 1'b0, 1'b1, 1'b0, 5'd0});
        fk(8'h3C);
        chk("ovf_idle_k281", {63'd0, buf_done}, 64'd0);

        // Repeated K28.0 restarts addressing
        fk(8'h1C);
        fb(8'hAA);
        fb(8'hBB);
        fk(8'h1C);
        chk("restart_no_done", {62'd0, buf_done, buf_wr_en}, 64'd0);
        fb(8'h10);
        chk("restart_addr0", {47'd0, buf_wr_en, 3'd0, buf_wr_addr, buf_wr_data}, {47'd0, 1'b1, 3'd0, 5'd0, 8'h10});
        fb(8'hFF);
        fb(8'hEF);
        fk(8'h3C);
        chk("restart_frame", {56'd0, buf_done, buf_ok, 1'b0, buf_len}, {56'd0, 1'b1, 1'b1, 1'b0, 5'd1});

        // Frame shorter than the checksum
        fk(8'h1C);
        fb(8'h05);
        fk(8'h3C);
        chk("short_frame", {56'd0, buf_done, buf_ok, 1'b0, buf_len}, {56'd0, 1'b1, 1'b0, 1'b0, 5'd0});

        // Unexpected K character aborts
        fk(8'h1C);
        fb(8'h05);
        fk(8'hF7);
        chk("other_k_abort", {56'd0, buf_done, buf_ok, 1'b0, buf_len}, {56'd0, 1'b1, 1'b0, 1'b0, 5'd0});

        // MGT not reset-done is a bad word but not a code error
        rx_reset_done = 1'b0;
        send(16'hBC00, 2'b10, 2'b00);
        rx_reset_done = 1'b1;
        chk("reset_done_low", {47'd0, link_up, err_count}, 64'd0);

        // Reset during RX returns to IDLE without buf_done
        qualify();
        fk(8'h1C);
        fb(8'h21);
        reset = 1'b1;
        #1;
        chk("async_reset", {9'd0, event_code, event_strobe, dbus, buf_wr_en, buf_wr_addr,
             buf_wr_data, buf_done, buf_ok, buf_len, link_up, err_count}, 64'd0);
        @(posedge ref_clk);
        #1;
        reset = 1'b0;
        fk(8'h3C);
        chk("reset_no_done", {63'd0, buf_done}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/evr_stream_decoder.md
Name: evr_stream_decoder

Overview:
- Consumes the aligned 16-bit 8b/10b-decoded word stream from the EVR MGT (recovered-clock domain) and splits it into three outputs: event codes, the distributed bus, and segmented data-buffer frames.
- Qualifies link health and counts code errors.
- Drives an external byte RAM write port and the event/timestamp logic downstream.

Parameters:
- LINK_GOOD_WORDS, 256, consecutive clean words required before link_up asserts (>=2).
- MAX_BYTES, 2048, maximum data-buffer payload bytes, excluding the 2 checksum bytes.
- ADDR_W, 11, buffer RAM address width; must satisfy 2**ADDR_W >= MAX_BYTES+2.

Ports:
- ref_clk  in  1  MGT recovered clock; all logic runs on it.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  16  MGT parallel word; [15:8] = event byte, [7:0] = data byte.
- rx_charisk  in  2  K-character flags, per byte.
- rx_notintable  in  2  8b/10b code-error flags, per byte.
- rx_reset_done  in  1  MGT reset done, already synchronous to ref_clk.
- err_clr  in  1  synchronous clear of err_count.
- event_code  out  8  last valid event code.
- event_strobe  out  1  one-cycle pulse qualifying event_code.
- dbus  out  8  distributed bus value.
- buf_wr_en  out  1  buffer RAM write enable.
- buf_wr_addr  out  ADDR_W  buffer RAM write address.
- buf_wr_data  out  8  buffer RAM write data.
- buf_done  out  1  one-cycle frame-complete pulse.
- buf_ok  out  1  frame checksum/format good; valid with buf_done.
- buf_len  out  ADDR_W  payload length in bytes; valid with buf_done.
- link_up  out  1  link qualified.
- err_count  out  16  saturating code-error count.

Behaviour:
- Reset: all outputs 0, frame FSM in IDLE, slot = 0, good-word counter = 0.
- All outputs are registered. Latency is 1 ref_clk from the input word to the outputs it produces.
- A word is "bad" when rx_notintable != 0 or rx_reset_done = 0.

Link qualification:
- A bad word clears link_up and the good counter on the next edge.
- link_up sets on the edge that completes LINK_GOOD_WORDS consecutive clean words.

Error counter:
- err_count increments by 1 per word with rx_notintable != 0 and saturates at 0xFFFF.
- err_clr has priority over increment and is honoured regardless of link_up.

Event byte:
- event_strobe = 1 when link_up is 1, rx_charisk[1] = 0, rx_data[15:8] != 0x00, and the word is not bad.
- event_code captures the byte on that cycle and holds otherwise.
- Event byte K28.5 (0xBC, k = 1) is idle/comma.

Data-byte slot:
- A word whose event byte is K28.5 is slot 0. slot toggles on every word after it.
- Slot 0: if k = 0 and link_up = 1, the byte updates dbus; otherwise dbus holds.
- Slot 1 bytes feed the frame FSM.

Frame FSM (states IDLE, RX):
- IDLE: K28.0 (0x1C, k = 1) in slot 1 with link_up -> RX. Byte index clears, sum clears.
- RX, k = 0 byte:
  - Write the byte to buf_wr_addr = index (includes the checksum bytes).
  - index += 1; sum16 += byte; the last-two-bytes shift register updates.
- RX, K28.1 (0x3C, k = 1) -> IDLE. buf_done pulses.
  - If index >= 2: buf_len = index - 2. buf_ok = 1 iff (sum16 - b_prev - b_last) + {b_prev, b_last} == 0xFFFF (mod 2^16), where b_prev is the earlier of the two bytes.
  - If index < 2: buf_len = 0, buf_ok = 0.
- RX, K28.0 again: restart. No buf_done; index and sum clear.
- RX, any other K character, a bad word, or link_up falling: abort -> IDLE. buf_done pulses with buf_ok = 0 and buf_len = 0.
- RX, a data byte when index = MAX_BYTES+2: overflow. No write; abort as above.
- Slot-0 bytes in RX are not frame bytes and do not advance the FSM.
- reset during RX: immediate return to IDLE. No buf_done.

Test Plan:
- Hold rx_reset_done = 1 with clean idle words (0xBC00, k = 2'b10) for 256 cycles -> link_up rises on the cycle after word 256; err_count = 0.
- With link up, word 0x2A00 (k = 00) -> event_strobe high exactly 1 cycle later with event_code = 0x2A. Word 0x0000 -> no strobe.
- With link up, a slot-0 data byte of 0x5A -> dbus = 0x5A; slot-1 bytes do not alter dbus.
- Frame: slot-1 sequence K28.0, 0x01, 0x02, 0x03, 0xFF, 0xF9, K28.1 -> 5 writes to addr 0..4; buf_done with buf_len = 3, buf_ok = 1. Same frame with checksum 0xFFF8 -> buf_ok = 0.
- rx_notintable = 2'b01 mid-frame -> link_up drops, buf_done with buf_ok = 0 and buf_len = 0, err_count += 1. Apply 70000 error words -> err_count = 0xFFFF; err_clr -> 0.
- Frame with MAX_BYTES+3 data bytes -> writes stop at addr MAX_BYTES+1; abort buf_done with buf_ok = 0. Repeated K28.0 mid-frame -> no buf_done and addressing restarts at 0.
